// File: rtl/serial_tx.sv
// 8N1/8N2 (8E1/8E2 with SERIAL_TX_PARITY_EN) serial transmitter, baud from a divided serclk.
// Two-entry holding FIFO in front of the shifter; back-to-back frames leave no idle gap.
module serial_tx #(
  parameter int TICKS_PER_BIT = 16,
  parameter int STOP_BITS     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serclk,
  input  logic [7:0] din,
  input  logic       wr,
  output logic       full,
  output logic       busy,
  output logic       txd
);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  localparam logic [7:0] TPB_LAST = 8'(TICKS_PER_BIT - 1);
  localparam logic       SB_LAST  = 1'(STOP_BITS - 1);

  state_t      r_state;
  logic [1:0]  r_sync;
  logic        r_hist;
  logic [7:0]  r_mem [0:1];
  logic        r_rd, r_wr;
  logic [1:0]  r_cnt;
  logic [7:0]  r_tcnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_sbit;
  logic        r_txd;
`ifdef SERIAL_TX_PARITY_EN
  logic        r_par;
`endif

  logic w_tick, w_full, w_push, w_bnd, w_stop_done, w_pop;

  // serclk is asynchronous to clk; only its synchronized rising edge is used
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], serclk};
      r_hist <= r_sync[1];
    end
  end

  assign w_tick      = r_sync[1] & ~r_hist;
  assign w_full      = (r_cnt == 2'd2);
  assign w_push      = wr & ~w_full;
  assign w_bnd       = w_tick && (r_tcnt == TPB_LAST);
  assign w_stop_done = (r_state == S_STOP) && w_bnd && (r_sbit == SB_LAST);
  assign w_pop       = (r_cnt != 2'd0) && ((r_state == S_IDLE) || w_stop_done);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_wr <= ~r_wr;
      if (w_pop)  r_rd <= ~r_rd;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_sbit  <= 1'b0;
      r_txd   <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      if (r_state != S_IDLE && w_tick) r_tcnt <= w_bnd ? 8'd0 : r_tcnt + 8'd1;
      case (r_state)
        S_IDLE: ;
        S_START: if (w_bnd) begin
          r_state <= S_DATA;
          r_txd   <= r_shift[0];
        end
        S_DATA: if (w_bnd) begin
          if (r_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
            r_state <= S_PAR;
            r_txd   <= r_par;
`else
            r_state <= S_STOP;
            r_txd   <= 1'b1;
            r_sbit  <= 1'b0;
`endif
          end else begin
            r_shift <= r_shift >> 1;
            r_idx   <= r_idx + 3'd1;
            r_txd   <= r_shift[1];
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        S_PAR: if (w_bnd) begin
          r_state <= S_STOP;
          r_txd   <= 1'b1;
          r_sbit  <= 1'b0;
        end
`endif
        S_STOP: if (w_bnd) begin
          if (r_sbit == SB_LAST) begin
            r_state <= S_IDLE;
            r_txd   <= 1'b1;
          end else begin
            r_sbit  <= r_sbit + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // a pop overrides the case above so the next start bit follows the last stop bit directly
      if (w_pop) begin
        r_shift <= r_mem[r_rd];
`ifdef SERIAL_TX_PARITY_EN
        r_par   <= ^r_mem[r_rd];
`endif
        r_tcnt  <= '0;
        r_idx   <= '0;
        r_txd   <= 1'b0;
        r_state <= S_START;
      end
    end
  end

  assign full = w_full;
  assign busy = (r_state != S_IDLE) || (r_cnt != 2'd0);
  assign txd  = r_txd;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: frame-queue line model checked every cycle, plus hand-computed bit sequences.
// Instance A runs 1 tick/bit with 1 stop bit; instance B runs 16 ticks/bit with 2 stop bits.
module tb_serial_tx;
`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int TPB_A = 1, SB_A = 1, TPB_B = 16, SB_B = 2;

  logic       clk = 1'b0, reset = 1'b1, serclk = 1'b0;
  logic [7:0] din = '0, din_b = '0;
  logic       wr = 1'b0, wr_b = 1'b0;
  logic       full, busy, txd, full_b, busy_b, txd_b;
  int         checks = 0, failures = 0;
  bit         run = 1'b0;

  always #5 clk = ~clk;

  // serclk = clk/8, changed on the falling edge
  int sc = 0;
  initial forever begin
    @(negedge clk);
    sc = (sc == 7) ? 0 : sc + 1;
    serclk = (sc >= 4);
  end

  serial_tx #(.TICKS_PER_BIT(TPB_A), .STOP_BITS(SB_A)) u_a (
    .clk(clk), .reset(reset), .serclk(serclk), .din(din), .wr(wr),
    .full(full), .busy(busy), .txd(txd));

  serial_tx #(.TICKS_PER_BIT(TPB_B), .STOP_BITS(SB_B)) u_b (
    .clk(clk), .reset(reset), .serclk(serclk), .din(din_b), .wr(wr_b),
    .full(full_b), .busy(busy_b), .txd(txd_b));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of instance A: byte queue plus a queue of pending line levels, one per bit period.
  logic [7:0] mq[$];
  bit         mb[$];
  int         m_left = 0;
  bit         m_act = 1'b0;
  bit [2:0]   sh = '0;
  bit         m_tk, m_was, m_end, m_dummy;
  int         m_n;
  logic [7:0] m_b;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete(); mb.delete();
      m_act = 1'b0; m_left = 0; sh = '0;
    end else begin
      // a serclk rise seen at edge k is acted on at edge k+2
      m_tk  = sh[1] & ~sh[2];
      m_n   = mq.size();
      m_was = m_act;
      m_end = 1'b0;
      if (m_act && m_tk) begin
        m_left--;
        if (m_left == 0) begin
          m_dummy = mb.pop_front();
          if (mb.size() == 0) begin m_act = 1'b0; m_end = 1'b1; end
          else m_left = TPB_A;
        end
      end
      if (m_n != 0 && (!m_was || m_end)) begin
        m_b = mq.pop_front();
        mb.push_back(1'b0);
        for (int i = 0; i < 8; i++) mb.push_back(m_b[i]);
        if (P == 1) mb.push_back(^m_b);
        for (int i = 0; i < SB_A; i++) mb.push_back(1'b1);
        m_act  = 1'b1;
        m_left = TPB_A;
      end
      if (wr && m_n < 2) mq.push_back(din);
      sh = {sh[1:0], serclk};
    end
  end

  initial forever begin
    @(negedge clk);
    if (run && !reset) begin
      chk("cyc txd",  txd,  m_act ? mb[0] : 1'b1);
      chk("cyc busy", busy, m_act || (mq.size() != 0));
      chk("cyc full", full, mq.size() == 2);
    end
  end

  task automatic timeout(input string name);
    checks++; failures++;
    $display("FAIL %s: timed out waiting for the line", name);
  endtask

  task automatic wait_lvl(input string name, input logic lvl, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (txd === lvl) begin ok = 1'b1; break; end
    end
    if (!ok) timeout(name);
  endtask

  task automatic wr_byte(input logic [7:0] d);
    wr = 1'b1; din = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  // Locate the start bit, then the rise into data bit 0 (must be 1), and sample mid-bit from there.
  task automatic check_seq(input string name, input logic [63:0] exp, input int n);
    bit ok;
    wait_lvl({name, " start"}, 1'b0, 200, ok);
    if (ok) wait_lvl({name, " d0"}, 1'b1, 40, ok);
    if (ok) begin
      repeat (4) @(negedge clk);
      for (int k = 0; k < n; k++) begin
        if (k > 0) repeat (8) @(negedge clk);
        chk($sformatf("%s bit%0d", name, k), txd, exp[k]);
      end
    end
  endtask

  // Counts clk cycles from now until txd_b falls after having been high.
  task automatic b_gap(output int t, output bit ok);
    bit seen = 1'b0;
    ok = 1'b0; t = 0;
    for (int i = 1; i <= 4000; i++) begin
      @(negedge clk);
      if (txd_b === 1'b1) seen = 1'b1;
      else if (seen && txd_b === 1'b0) begin t = i; ok = 1'b1; break; end
    end
    if (!ok) timeout("b frame gap");
  endtask

  initial begin
    bit ok, bad;
    int t;
    @(negedge clk);
    chk("reset txd",  txd,  1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset full", full, 1'b0);
    chk("reset txd_b",  txd_b,  1'b1);
    chk("reset busy_b", busy_b, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    run   = 1'b1;
    repeat (10) @(negedge clk);

    // single byte 0xA5
    wr_byte(8'hA5);
    chk("a5 busy after wr", busy, 1'b1);
`ifdef SERIAL_TX_PARITY_EN
    check_seq("a5", {2'b11, 1'b0, 8'hA5}, 11);
`else
    check_seq("a5", {2'b11, 8'hA5}, 10);
`endif
    chk("a5 busy after stop", busy, 1'b0);
    repeat (20) @(negedge clk);

    // four writes in a row: the third fills the FIFO, the fourth is dropped
    wr = 1'b1; din = 8'h01; @(negedge clk);
    din = 8'h02; @(negedge clk);
    chk("b2b full after 2nd", full, 1'b0);
    din = 8'h03; @(negedge clk);
    chk("b2b full after 3rd", full, 1'b1);
    din = 8'h04; @(negedge clk);
    wr = 1'b0;
    chk("b2b full after 4th", full, 1'b1);
`ifdef SERIAL_TX_PARITY_EN
    check_seq("b2b", {2'b11, 1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01}, 34);
`else
    check_seq("b2b", {2'b11, 1'b1, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h01}, 31);
`endif
    chk("b2b idle busy", busy, 1'b0);
    repeat (20) @(negedge clk);

`ifdef SERIAL_TX_PARITY_EN
    wr_byte(8'h07);
    check_seq("par 07", {2'b11, 1'b1, 8'h07}, 11);
    repeat (10) @(negedge clk);
    wr_byte(8'h03);
    check_seq("par 03", {2'b11, 1'b0, 8'h03}, 11);
    repeat (10) @(negedge clk);
`endif

    // reset in the middle of data bit 3 of 0x55, with 0x66 waiting in the FIFO
    wr_byte(8'h55);
    wr_byte(8'h66);
    wait_lvl("rst start", 1'b0, 200, ok);
    if (ok) wait_lvl("rst d0", 1'b1, 40, ok);
    if (ok) begin
      repeat (28) @(negedge clk);
      chk("rst pre txd", txd, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("rst txd",  txd,  1'b1);
      chk("rst busy", busy, 1'b0);
      chk("rst full", full, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      bad = 1'b0;
      repeat (200) begin
        @(negedge clk);
        if (txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      end
      chk("rst stays idle", bad, 1'b0);
    end

    // push and pop on the same edge: 0x3C written as the 0x81 frame ends
    wr_byte(8'h81);
    wr_byte(8'h11);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (m_act && mb.size() == 1 && m_left == 1 && sh[1] && !sh[2]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) timeout("pushpop frame end");
    else begin
      wr = 1'b1; din = 8'h3C;
      @(negedge clk);
      wr = 1'b0;
      chk("pushpop full", full, 1'b0);
      chk("pushpop busy", busy, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (busy === 1'b0) begin ok = 1'b1; break; end
      end
      if (!ok) timeout("pushpop drain");
    end

    // instance B: frame length with 2 stop bits, measured start bit to start bit
    wr_b = 1'b1; din_b = 8'hFF;
    repeat (3) @(negedge clk);
    wr_b = 1'b0;
    chk("b full after 3 writes", full_b, 1'b1);
    b_gap(t, ok);
    if (ok) b_gap(t, ok);
    if (ok) chk("b frame ticks", t, (1 + 8 + P + SB_B) * TPB_B * 8);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (busy_b === 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("b drain");
    chk("b idle full", full_b, 1'b0);
    chk("b idle txd",  txd_b,  1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
